// File: rtl/pipelined_cla_addsub.sv
// Pipelined carry-lookahead adder/subtractor.
// A WIDTH-bit add/sub is split into BLOCK-bit lookahead slices, one slice per
// pipeline stage; the slice carry is registered between stages and the upper,
// not-yet-summed operand bits travel forward unchanged. A single advance enable
// (downstream ready or empty output slot) stalls the whole pipe at once.
module pipelined_cla_addsub #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned BLOCK = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_add1,
    input  logic [WIDTH-1:0] i_add2,
    input  logic             i_cin,
    input  logic             i_sub,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_result,
    output logic             o_cout,
    output logic             o_ovf,
    output logic             o_zero
);

    localparam int unsigned STAGES = WIDTH / BLOCK;

    if (BLOCK == 0 || WIDTH < BLOCK || (WIDTH % BLOCK) != 0) begin : g_bad_params
        $error("pipelined_cla_addsub: WIDTH must be a non-zero multiple of BLOCK");
    end

    // Lookahead slice: every carry is a flat sum of generate terms gated by the
    // propagate run above them, so no carry depends on a lower computed carry.
    function automatic logic [BLOCK:0] cla_slice(
        input logic [BLOCK-1:0] a,
        input logic [BLOCK-1:0] b,
        input logic             cin
    );
        logic [BLOCK-1:0] g;
        logic [BLOCK-1:0] p;
        logic [BLOCK:0]   c;
        logic             term;
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        c[0] = cin;
        for (int unsigned i = 0; i < BLOCK; i++) begin
            term = cin;
            for (int unsigned j = 0; j <= i; j++) begin
                term = term & p[j];
            end
            c[i+1] = term;
            for (int unsigned j = 0; j <= i; j++) begin
                term = g[j];
                for (int unsigned m = j + 1; m <= i; m++) begin
                    term = term & p[m];
                end
                c[i+1] = c[i+1] | term;
            end
        end
        return {c[BLOCK], p ^ c[BLOCK-1:0]};
    endfunction

    // Stage registers: index k holds the state leaving stage k.
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];
    logic [WIDTH-1:0]  a_d [STAGES];
    logic [WIDTH-1:0]  b_d [STAGES];
    logic [WIDTH-1:0]  s_d [STAGES];
    logic [STAGES-1:0] c_q;
    logic [STAGES-1:0] c_d;
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] v_d;
    logic              ovf_q;
    logic              ovf_d;
    logic              zero_q;
    logic              zero_d;

    // Per-stage working values (reused across loop iterations).
    logic [WIDTH-1:0]  a_w;
    logic [WIDTH-1:0]  b_w;
    logic [WIDTH-1:0]  s_w;
    logic              c_w;
    logic              v_w;
    logic [BLOCK:0]    slice_w;

    logic              en;

    assign en       = !v_q[STAGES-1] || i_ready;
    assign o_ready  = en;
    assign o_valid  = v_q[STAGES-1];
    assign o_result = s_q[STAGES-1];
    assign o_cout   = c_q[STAGES-1];
    assign o_ovf    = ovf_q;
    assign o_zero   = zero_q;

    // Next state of every stage: stage 0 takes the effective operands, later
    // stages take the previous register; each fills in its own sum slice.
    // Flags come from the last stage, where the full sum and operand MSBs meet.
    always_comb begin
        a_d     = '{default: '0};
        b_d     = '{default: '0};
        s_d     = '{default: '0};
        c_d     = '0;
        v_d     = '0;
        a_w     = '0;
        b_w     = '0;
        s_w     = '0;
        c_w     = 1'b0;
        v_w     = 1'b0;
        slice_w = '0;
        for (int unsigned k = 0; k < STAGES; k++) begin
            if (k == 0) begin
                a_w = i_add1;
                b_w = i_sub ? ~i_add2 : i_add2;
                c_w = i_cin ^ i_sub;
                s_w = '0;
                v_w = i_valid;
            end else begin
                a_w = a_q[k-1];
                b_w = b_q[k-1];
                c_w = c_q[k-1];
                s_w = s_q[k-1];
                v_w = v_q[k-1];
            end
            slice_w = cla_slice(a_w[k*BLOCK +: BLOCK], b_w[k*BLOCK +: BLOCK], c_w);
            s_w[k*BLOCK +: BLOCK] = slice_w[BLOCK-1:0];
            a_d[k] = a_w;
            b_d[k] = b_w;
            s_d[k] = s_w;
            c_d[k] = slice_w[BLOCK];
            v_d[k] = v_w;
        end
        ovf_d  = (a_w[WIDTH-1] == b_w[WIDTH-1]) && (s_w[WIDTH-1] != a_w[WIDTH-1]);
        zero_d = (s_w == '0);
    end

    // Pipeline registers: cleared on reset, advance together only when enabled.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            v_q    <= '0;
            c_q    <= '0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
            for (int unsigned k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else if (en) begin
            v_q    <= v_d;
            c_q    <= c_d;
            a_q    <= a_d;
            b_q    <= b_d;
            s_q    <= s_d;
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Bench for pipelined_cla_addsub: three instances (8/4, 32/8, 8/8) share one
// operand stream; each has its own ready line and scoreboard queue.
module tb_pipelined_cla_addsub;

    logic        clk;
    logic        rst;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic        valid;
    logic        rdy_n;
    logic        rdy_w;
    logic        rdy_s;

    logic        n_ordy, n_ovld, n_cout, n_ovf, n_zero;
    logic [7:0]  n_res;
    logic        w_ordy, w_ovld, w_cout, w_ovf, w_zero;
    logic [31:0] w_res;
    logic        s_ordy, s_ovld, s_cout, s_ovf, s_zero;
    logic [7:0]  s_res;

    int checks = 0;
    int errors = 0;
    int n_acc = 0, w_acc = 0, s_acc = 0;
    int n_pops = 0;

    logic [63:0] q_n[$];
    logic [63:0] q_w[$];
    logic [63:0] q_s[$];

    logic        held_n_v = 1'b0, held_w_v = 1'b0, held_s_v = 1'b0;
    logic [63:0] held_n, held_w, held_s;

    pipelined_cla_addsub #(.WIDTH(8), .BLOCK(4)) u_dut_n (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(n_ordy),
        .i_add1(a[7:0]), .i_add2(b[7:0]), .i_cin(cin), .i_sub(sub),
        .o_valid(n_ovld), .i_ready(rdy_n), .o_result(n_res),
        .o_cout(n_cout), .o_ovf(n_ovf), .o_zero(n_zero)
    );

    pipelined_cla_addsub #(.WIDTH(32), .BLOCK(8)) u_dut_w (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(w_ordy),
        .i_add1(a), .i_add2(b), .i_cin(cin), .i_sub(sub),
        .o_valid(w_ovld), .i_ready(rdy_w), .o_result(w_res),
        .o_cout(w_cout), .o_ovf(w_ovf), .o_zero(w_zero)
    );

    pipelined_cla_addsub #(.WIDTH(8), .BLOCK(8)) u_dut_s (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(s_ordy),
        .i_add1(a[7:0]), .i_add2(b[7:0]), .i_cin(cin), .i_sub(sub),
        .o_valid(s_ovld), .i_ready(rdy_s), .o_result(s_res),
        .o_cout(s_cout), .o_ovf(s_ovf), .o_zero(s_zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pk(input logic [31:0] r, input logic c, input logic o, input logic z);
        return {29'd0, z, o, c, r};
    endfunction

    // Behavioural reference using wide integer arithmetic.
    function automatic logic [63:0] model(input int unsigned w, input logic [31:0] ia,
                                          input logic [31:0] ib, input logic icin, input logic isub);
        longint mask, ua, ub, ci, full, lim, sa, sb, sv;
        logic [31:0] res;
        logic        cout;
        logic        ovf;
        mask = (64'sd1 <<< w) - 64'sd1;
        ua   = {32'd0, ia};
        ub   = {32'd0, ib};
        ua   = ua & mask;
        ub   = ub & mask;
        ci   = icin ? 64'sd1 : 64'sd0;
        full = isub ? (ua - ub - ci) : (ua + ub + ci);
        res  = full[31:0] & mask[31:0];
        cout = isub ? (full >= 0) : full[w];
        lim  = 64'sd1 <<< (w - 1);
        sa   = (ua >= lim) ? ua - (lim <<< 1) : ua;
        sb   = (ub >= lim) ? ub - (lim <<< 1) : ub;
        sv   = isub ? (sa - sb - ci) : (sa + sb + ci);
        ovf  = (sv >= lim) || (sv < -lim);
        return pk(res, cout, ovf, res == 32'd0);
    endfunction

    // Scoreboard for the 8/4 instance: compare/pop on consume, push on accept.
    always @(negedge clk) begin
        if (rst) begin
            q_n.delete();
            held_n_v = 1'b0;
        end else begin
            check("n_ready", {63'd0, n_ordy}, {63'd0, !n_ovld || rdy_n});
            if (held_n_v) begin
                check("n_hold_valid", {63'd0, n_ovld}, 64'd1);
                check("n_hold_data", pk({24'd0, n_res}, n_cout, n_ovf, n_zero), held_n);
            end
            if (n_ovld && rdy_n) begin
                if (q_n.size() == 0) check("n_spurious", {63'd0, n_ovld}, 64'd0);
                else begin
                    check("n_result", pk({24'd0, n_res}, n_cout, n_ovf, n_zero), q_n.pop_front());
                    n_pops++;
                end
            end
            if (valid && n_ordy) begin
                q_n.push_back(model(8, a, b, cin, sub));
                n_acc++;
            end
            held_n_v = n_ovld && !rdy_n;
            held_n   = pk({24'd0, n_res}, n_cout, n_ovf, n_zero);
        end
    end

    // Scoreboard for the 32/8 instance.
    always @(negedge clk) begin
        if (rst) begin
            q_w.delete();
            held_w_v = 1'b0;
        end else begin
            check("w_ready", {63'd0, w_ordy}, {63'd0, !w_ovld || rdy_w});
            if (held_w_v) begin
                check("w_hold_valid", {63'd0, w_ovld}, 64'd1);
                check("w_hold_data", pk(w_res, w_cout, w_ovf, w_zero), held_w);
            end
            if (w_ovld && rdy_w) begin
                if (q_w.size() == 0) check("w_spurious", {63'd0, w_ovld}, 64'd0);
                else check("w_result", pk(w_res, w_cout, w_ovf, w_zero), q_w.pop_front());
            end
            if (valid && w_ordy) begin
                q_w.push_back(model(32, a, b, cin, sub));
                w_acc++;
            end
            held_w_v = w_ovld && !rdy_w;
            held_w   = pk(w_res, w_cout, w_ovf, w_zero);
        end
    end

    // Scoreboard for the single-stage 8/8 instance.
    always @(negedge clk) begin
        if (rst) begin
            q_s.delete();
            held_s_v = 1'b0;
        end else begin
            check("s_ready", {63'd0, s_ordy}, {63'd0, !s_ovld || rdy_s});
            if (held_s_v) begin
                check("s_hold_valid", {63'd0, s_ovld}, 64'd1);
                check("s_hold_data", pk({24'd0, s_res}, s_cout, s_ovf, s_zero), held_s);
            end
            if (s_ovld && rdy_s) begin
                if (q_s.size() == 0) check("s_spurious", {63'd0, s_ovld}, 64'd0);
                else check("s_result", pk({24'd0, s_res}, s_cout, s_ovf, s_zero), q_s.pop_front());
            end
            if (valid && s_ordy) begin
                q_s.push_back(model(8, a, b, cin, sub));
                s_acc++;
            end
            held_s_v = s_ovld && !rdy_s;
            held_s   = pk({24'd0, s_res}, s_cout, s_ovf, s_zero);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-cycle issue with all readies high (every instance accepts).
    task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic icin, input logic isub);
        a = ia; b = ib; cin = icin; sub = isub; valid = 1'b1;
        step();
        valid = 1'b0;
    endtask

    // Directed expectation for the 8/4 instance, one cycle after issue() returns.
    task automatic expect_n(input string tag, input logic [7:0] r, input logic c, input logic o, input logic z);
        step();
        check(tag, pk({24'd0, n_res}, n_cout, n_ovf, n_zero), pk({24'd0, r}, c, o, z));
        check({tag, "_valid"}, {63'd0, n_ovld}, 64'd1);
    endtask

    logic [31:0] sa [8];
    logic [31:0] sb [8];
    int          sent;
    int          pops0;
    int          cyc;

    initial begin
        rst = 1'b1; a = '0; b = '0; cin = 1'b0; sub = 1'b0; valid = 1'b0;
        rdy_n = 1'b1; rdy_w = 1'b1; rdy_s = 1'b1;
        repeat (3) step();
        rst = 1'b0;

        // Reset state.
        check("rst_n", pk({24'd0, n_res}, n_cout, n_ovf, n_zero), 64'd0);
        check("rst_n_valid", {63'd0, n_ovld}, 64'd0);
        check("rst_n_ready", {63'd0, n_ordy}, 64'd1);
        check("rst_w", pk(w_res, w_cout, w_ovf, w_zero), 64'd0);
        check("rst_w_valid", {63'd0, w_ovld}, 64'd0);
        check("rst_s_valid", {63'd0, s_ovld}, 64'd0);

        // Basic add and latency of each configuration.
        issue(32'h3C, 32'h05, 1'b0, 1'b0);
        check("lat_n_early", {63'd0, n_ovld}, 64'd0);
        check("lat_s", {63'd0, s_ovld}, 64'd1);
        check("lat_s_res", {56'd0, s_res}, 64'h41);
        check("lat_w_early1", {63'd0, w_ovld}, 64'd0);
        expect_n("add_basic", 8'h41, 1'b0, 1'b0, 1'b0);
        check("lat_w_early2", {63'd0, w_ovld}, 64'd0);
        step();
        check("lat_w_early3", {63'd0, w_ovld}, 64'd0);
        step();
        check("lat_w", {63'd0, w_ovld}, 64'd1);
        check("lat_w_res", {32'd0, w_res}, 64'h41);

        // Carry across slice, signed overflow, subtract with borrow.
        issue(32'hFF, 32'h01, 1'b0, 1'b0);
        expect_n("carry_wrap", 8'h00, 1'b1, 1'b0, 1'b1);
        issue(32'h7F, 32'h01, 1'b0, 1'b0);
        expect_n("ovf_pos", 8'h80, 1'b0, 1'b1, 1'b0);
        issue(32'h05, 32'h07, 1'b0, 1'b1);
        expect_n("sub_borrow", 8'hFE, 1'b0, 1'b0, 1'b0);
        issue(32'h10, 32'h01, 1'b1, 1'b1);
        expect_n("sub_bin", 8'h0E, 1'b1, 1'b0, 1'b0);
        issue(32'h80, 32'h01, 1'b0, 1'b1);
        expect_n("sub_ovf", 8'h7F, 1'b1, 1'b1, 1'b0);
        repeat (4) step();

        // Back-to-back stream with a 3-cycle downstream stall on the 8/4 instance.
        for (int i = 0; i < 8; i++) begin
            sa[i] = $urandom;
            sb[i] = $urandom;
        end
        sent  = 0;
        pops0 = n_pops;
        for (int cy = 0; cy < 40 && sent < 8; cy++) begin
            a = sa[sent]; b = sb[sent]; cin = sent[0]; sub = sent[1]; valid = 1'b1;
            rdy_n = (cy >= 5 && cy < 8) ? 1'b0 : 1'b1;
            #3;
            if (cy == 6) check("stall_ready", {63'd0, n_ordy}, 64'd0);
            if (n_ordy) sent++;
            @(posedge clk);
            #1;
        end
        valid = 1'b0;
        rdy_n = 1'b1;
        check("stream_sent", sent, 64'd8);
        repeat (2) step();
        check("stream_results", n_pops - pops0, 64'd8);
        check("stream_drained", q_n.size(), 64'd0);
        repeat (6) step();

        // Reset mid-flight: one op in the pipe, a second presented with reset.
        issue($urandom, $urandom, 1'b0, 1'b0);
        a = $urandom; b = $urandom; valid = 1'b1; rst = 1'b1;
        step();
        rst = 1'b0; valid = 1'b0;
        check("midrst_n", pk({24'd0, n_res}, n_cout, n_ovf, n_zero), 64'd0);
        check("midrst_n_valid", {63'd0, n_ovld}, 64'd0);
        check("midrst_n_ready", {63'd0, n_ordy}, 64'd1);
        check("midrst_w_valid", {63'd0, w_ovld}, 64'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("midrst_quiet", {63'd0, n_ovld}, 64'd0);
        end
        issue(32'h12, 32'h34, 1'b1, 1'b0);
        check("postrst_early", {63'd0, n_ovld}, 64'd0);
        expect_n("postrst", 8'h47, 1'b0, 1'b0, 1'b0);
        repeat (6) step();

        // Random traffic with random valid/ready on all three instances.
        n_acc = 0; w_acc = 0; s_acc = 0;
        cyc = 0;
        while ((n_acc < 1000 || w_acc < 1000 || s_acc < 1000) && cyc < 8000) begin
            a = $urandom; b = $urandom;
            if ($urandom_range(0, 7) == 0) b = ~a;
            if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFFF;
            cin   = 1'($urandom_range(0, 1));
            sub   = 1'($urandom_range(0, 1));
            valid = ($urandom_range(0, 3) != 0);
            rdy_n = ($urandom_range(0, 3) != 0);
            rdy_w = ($urandom_range(0, 3) != 0);
            rdy_s = ($urandom_range(0, 3) != 0);
            step();
            cyc++;
        end
        valid = 1'b0; rdy_n = 1'b1; rdy_w = 1'b1; rdy_s = 1'b1;
        check("rand_budget", {63'd0, n_acc >= 1000 && w_acc >= 1000 && s_acc >= 1000}, 64'd1);
        repeat (8) step();
        check("rand_drain_n", q_n.size(), 64'd0);
        check("rand_drain_w", q_w.size(), 64'd0);
        check("rand_drain_s", q_s.size(), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
